// File: rtl/mix_cols_pkg.sv
// mix_cols_pkg: shared GF(2^8) helpers for the AES MixColumns datapath.
//   GF_RED         reduction constant for the AES field polynomial 0x11B
//   col_t          one 32-bit state column, row 0 byte in bits [31:24]
//   xtime()        multiply by 2 in GF(2^8)
//   gf_mul_const() multiply by one of the constants 2, 3, 9, b, d, e
//                  (any other value multiplies by 1)
package mix_cols_pkg;

    localparam logic [7:0] GF_RED = 8'h1B;

    typedef logic [31:0] col_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
    endfunction

    // Constants are built from the doubling chain a, 2a, 4a, 8a.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            8'h02:   r = x2;
            8'h03:   r = x2 ^ a;
            8'h09:   r = x8 ^ a;
            8'h0B:   r = x8 ^ x2 ^ a;
            8'h0D:   r = x8 ^ x4 ^ a;
            8'h0E:   r = x8 ^ x4 ^ x2;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_single_col.sv
// mix_single_col: combinational MixColumns for one 32-bit column.
//   inv    (only with MIX_COLS_INV_EN) 1 = InvMixColumns, 0 = MixColumns
//   col    input column, row 0 byte in bits [31:24]
//   mixed  transformed column, same byte ordering
// Macro MIX_COLS_INV_EN adds the inv input and the inverse coefficients.
module mix_single_col
    import mix_cols_pkg::*;
(
`ifdef MIX_COLS_INV_EN
    input  logic inv,
`endif
    input  col_t col,
    output col_t mixed
);

    logic [7:0] a0, a1, a2, a3;
    col_t       fwd;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign fwd = {
        gf_mul_const(a0, 8'h02) ^ gf_mul_const(a1, 8'h03) ^ a2 ^ a3,
        a0 ^ gf_mul_const(a1, 8'h02) ^ gf_mul_const(a2, 8'h03) ^ a3,
        a0 ^ a1 ^ gf_mul_const(a2, 8'h02) ^ gf_mul_const(a3, 8'h03),
        gf_mul_const(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul_const(a3, 8'h02)
    };

`ifdef MIX_COLS_INV_EN
    col_t bwd;

    assign bwd = {
        gf_mul_const(a0, 8'h0E) ^ gf_mul_const(a1, 8'h0B) ^ gf_mul_const(a2, 8'h0D) ^ gf_mul_const(a3, 8'h09),
        gf_mul_const(a0, 8'h09) ^ gf_mul_const(a1, 8'h0E) ^ gf_mul_const(a2, 8'h0B) ^ gf_mul_const(a3, 8'h0D),
        gf_mul_const(a0, 8'h0D) ^ gf_mul_const(a1, 8'h09) ^ gf_mul_const(a2, 8'h0E) ^ gf_mul_const(a3, 8'h0B),
        gf_mul_const(a0, 8'h0B) ^ gf_mul_const(a1, 8'h0D) ^ gf_mul_const(a2, 8'h09) ^ gf_mul_const(a3, 8'h0E)
    };

    assign mixed = inv ? bwd : fwd;
`else
    assign mixed = fwd;
`endif

endmodule

// File: rtl/mix_cols.sv
// mix_cols: registered AES MixColumns over the full 128-bit state.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears mixed and out_valid)
//   in_valid   capture state this cycle
//   inv        (only with MIX_COLS_INV_EN) 1 = InvMixColumns
//   state      AES state, column c = state[127-32c -: 32]
//   out_valid  mixed holds a result captured at the previous edge
//   mixed      transformed state, same ordering; holds when in_valid=0
// Macro MIX_COLS_INV_EN adds the inv port and the inverse transform.
module mix_cols
    import mix_cols_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
`ifdef MIX_COLS_INV_EN
    input  logic         inv,
`endif
    input  logic [127:0] state,
    output logic         out_valid,
    output logic [127:0] mixed
);

    logic [127:0] mixed_next;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_col u_col (
`ifdef MIX_COLS_INV_EN
            .inv   (inv),
`endif
            .col   (state[127-32*c -: 32]),
            .mixed (mixed_next[127-32*c -: 32])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            mixed     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mixed <= mixed_next;
            end
        end
    end

endmodule

// File: tb/tb_mix_cols.sv
module tb_mix_cols;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] state = '0;
    logic         out_valid;
    logic [127:0] mixed;
`ifdef MIX_COLS_INV_EN
    logic         inv = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic         exp_valid;
    logic [127:0] exp_mixed;

    mix_cols dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef MIX_COLS_INV_EN
        .inv       (inv),
`endif
        .state     (state),
        .out_valid (out_valid),
        .mixed     (mixed)
    );

    always #5 clk = ~clk;

    // General GF(2^8) shift-and-add multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix product per column.
    function automatic logic [127:0] model(input logic [127:0] st, input bit inv_m);
        logic [7:0]   k [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inv_m) begin
            k[0] = 8'h0E; k[1] = 8'h0B; k[2] = 8'h0D; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = st[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(k[(j - i + 4) % 4], a[j]);
                r[127-32*c-8*i -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit cur_inv();
`ifdef MIX_COLS_INV_EN
        return inv;
`else
        return 1'b0;
`endif
    endfunction

    // Reference output register, driven from the model.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_mixed <= '0;
        end else begin
            exp_valid <= in_valid;
            if (in_valid) exp_mixed <= model(state, cur_inv());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            check("mixed", mixed, exp_mixed);
        end
    end

    task automatic send(input logic [127:0] st, input bit v, input bit iv);
        @(posedge clk);
        #2;
        state    = st;
        in_valid = v;
`ifdef MIX_COLS_INV_EN
        inv      = iv;
`else
        if (iv) $display("note: inverse request ignored without MIX_COLS_INV_EN");
`endif
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] v0, v1, v2, r, f, last;

    initial begin
        v0 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        v1 = 128'hdb135345f20a225c01010101c6c6c6c6;
        v2 = 128'hd4d4d4d52d26314cd4d4d4d52d26314c;

        // Model pinned to known-answer vectors.
        check("model_v0", model(v0, 1'b0), 128'h046681e5e0cb199a48f8d37a2806264c);
        check("model_v1", model(v1, 1'b0), 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        check("model_v2", model(v2, 1'b0), 128'hd5d5d7d64d7ebdf8d5d5d7d64d7ebdf8);
        check("model_inv", model(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1), v0);

        // Reset state, with a pending capture discarded.
        in_valid = 1'b1;
        state    = v0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mixed", mixed, '0);
        check("reset_valid", {127'd0, out_valid}, '0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Known-answer vectors through the DUT.
        send(v0, 1'b1, 1'b0);
        after_edge();
        check("kat_v0", mixed, 128'h046681e5e0cb199a48f8d37a2806264c);
        send(v1, 1'b1, 1'b0);
        after_edge();
        check("kat_v1", mixed, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        send(v2, 1'b1, 1'b0);
        after_edge();
        check("kat_v2", mixed, 128'hd5d5d7d64d7ebdf8d5d5d7d64d7ebdf8);

`ifdef MIX_COLS_INV_EN
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b1);
        after_edge();
        check("kat_inv", mixed, v0);
        for (int n = 0; n < 9; n++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, 1'b1, 1'b0);
            after_edge();
            f = mixed;
            send(f, 1'b1, 1'b1);
            after_edge();
            check("roundtrip", mixed, r);
        end
`endif

        // Three back-to-back captures then idle: mixed holds the last result.
        for (int n = 0; n < 3; n++) begin
            last = {$urandom, $urandom, $urandom, $urandom};
            send(last, 1'b1, 1'b0);
        end
        send('0, 1'b0, 1'b0);
        after_edge();
        check("b2b_last", mixed, model(last, 1'b0));
        after_edge();
        check("hold_valid", {127'd0, out_valid}, '0);
        check("hold_mixed", mixed, model(last, 1'b0));

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges while a capture is pending.
        send(v1, 1'b1, 1'b0);
        after_edge();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mixed", mixed, '0);
        check("async_valid", {127'd0, out_valid}, '0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (3) after_edge();
        check("post_rst_valid", {127'd0, out_valid}, '0);
        check("post_rst_mixed", mixed, '0);
        send(v2, 1'b1, 1'b0);
        after_edge();
        check("post_rst_first", mixed, 128'hd5d5d7d64d7ebdf8d5d5d7d64d7ebdf8);
        send('0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_cols.md
MIX_COLS -- requirements
Module: mix_cols

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 128-bit state and 32-bit column.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  qualifies state for capture this cycle.
REQ-005 state  input  128  AES state, column-major: column c = state[127-32c -: 32], row 0 byte in the MSB of the column.
REQ-006 out_valid  output  1  mixed holds a new result.
REQ-007 mixed  output  128  MixColumns result, same byte ordering as state.
REQ-008 inv  input  1  1 selects InvMixColumns; present only when MIX_COLS_INV_EN is defined.

Function
REQ-009 Per column (a0..a3, row 0 first), forward mode SHALL compute over GF(2^8), poly 0x11B:
- b0 = 2a0^3a1^a2^a3
- b1 = a0^2a1^3a2^a3
- b2 = a0^a1^2a2^3a3
- b3 = 3a0^a1^a2^2a3
REQ-010 Multiply-by-2 (xtime) SHALL be a left shift with conditional XOR of 0x1B when the shifted-out bit is 1; 3a = xtime(a)^a.
REQ-011 All four columns SHALL be processed in parallel and independently.
REQ-012 Latency SHALL be exactly 1 cycle: when in_valid=1 at edge N, mixed and out_valid=1 are valid after edge N.
REQ-013 When in_valid=0 at an edge, out_valid SHALL go 0 and mixed SHALL hold its previous value.
REQ-014 Back-to-back in_valid SHALL be accepted every cycle; there is no backpressure and no stall.
REQ-015 The datapath from state to the output register SHALL be purely combinational; no internal state exists beyond the output registers.

Reset
REQ-016 While rst_n=0, mixed SHALL be 128'h0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-017 Reset asserted while a capture is pending SHALL discard it; the first out_valid after release SHALL follow the first in_valid sampled with rst_n=1.

Configuration
REQ-018 Macro MIX_COLS_INV_EN SHALL control the inverse feature.
REQ-019 With MIX_COLS_INV_EN defined, the inv port SHALL exist and be sampled with in_valid. When inv=1 the block SHALL compute InvMixColumns with coefficients {0e,0b,0d,09} in circulant order:
- b0 = e·a0^b·a1^d·a2^9·a3
- b1..b3 rotate the coefficients accordingly
REQ-020 Without MIX_COLS_INV_EN, the inv port and the inverse logic SHALL be absent, and the block SHALL always compute forward MixColumns.

Structure
REQ-021 A shared package mix_cols_pkg SHALL hold:
- the reduction constant 0x1B
- the xtime function
- a GF(2^8) multiply-by-constant function (2, 3, 9, b, d, e)
- a 32-bit column typedef
REQ-022 A sub-module mix_single_col SHALL implement one column combinationally, with the inv input included under the same macro. It SHALL be instantiated four times in mix_cols.

Verification
REQ-023 state=d4bf5d30e0b452aeb84111f11e2798e5, in_valid=1 -> one cycle later mixed=046681e5e0cb199a48f8d37a2806264c, out_valid=1.
REQ-024 Columns db135345/f20a225c/01010101/c6c6c6c6 (state=db135345f20a225c01010101c6c6c6c6) -> mixed=8e4da1bc9fdc589d01010101c6c6c6c6.
REQ-025 Columns d4d4d4d5/2d26314c repeated (state=d4d4d4d52d26314cd4d4d4d52d26314c) -> mixed=d5d5d7d64d7ebdf8d5d5d7d64d7ebdf8.
REQ-026 MIX_COLS_INV_EN defined, inv=1, state=046681e5e0cb199a48f8d37a2806264c -> mixed=d4bf5d30e0b452aeb84111f11e2798e5; also forward followed by inverse on 9 random states SHALL return the original state.
REQ-027 Drive three back-to-back valid inputs, then in_valid=0 -> three consecutive correct outputs with out_valid=1, then out_valid=0 with mixed holding the last value.
REQ-028 Assert rst_n=0 mid-stream between clock edges -> mixed=0 and out_valid=0 immediately; after release with in_valid=0, out_valid stays 0.
